// File: rtl/wake_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// wake_bus_arbiter_if
//   Bundles the requester handshake and the wakeup/broadcast buses that the
//   wake_bus_arbiter sits between.
//
//   Requester side (execute units -> arbiter):
//     req_valid  [REQ_NUM]          result ready to broadcast
//     req_id     [REQ_NUM*ID_W]     destination physical reg, 0 = no destination
//     req_data   [REQ_NUM*32]       result word
//     req_ready  [REQ_NUM]          accepted this cycle (combinational)
//   Bus side (arbiter -> issue queues):
//     wake_valid [BUS_NUM]          bus k carries a wakeup
//     wake_id    [BUS_NUM*ID_W]     bus k reg id
//     broadcast  [BUS_NUM*32]       bus k data word
//
//   master : the side that drives requests and consumes the buses
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface wake_bus_arbiter_if #(
    parameter int REQ_NUM = 6,
    parameter int BUS_NUM = 2,
    parameter int ID_W    = 6
);
    logic [REQ_NUM-1:0]      req_valid;
    logic [REQ_NUM*ID_W-1:0] req_id;
    logic [REQ_NUM*32-1:0]   req_data;
    logic [REQ_NUM-1:0]      req_ready;

    logic [BUS_NUM-1:0]      wake_valid;
    logic [BUS_NUM*ID_W-1:0] wake_id;
    logic [BUS_NUM*32-1:0]   broadcast;

    modport master (
        output req_valid, req_id, req_data,
        input  req_ready, wake_valid, wake_id, broadcast
    );

    modport slave (
        input  req_valid, req_id, req_data,
        output req_ready, wake_valid, wake_id, broadcast
    );
endinterface

// File: rtl/wake_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wake_bus_arbiter
//   Shares BUS_NUM result/wakeup buses among REQ_NUM completing units
//   (ALUs, MEM, MUL, DIV). Up to BUS_NUM requesters are granted per cycle:
//   starved requesters first (ascending index), then round-robin from rr_ptr.
//   The g-th grant of a cycle drives bus g one cycle later, from registers.
//
//   Ports:
//     clk    in   clock
//     reset  in   synchronous, active-high; dominates flush
//     flush  in   pipeline flush: drops in-flight grants, restarts arbitration
//     bus    slave modport of wake_bus_arbiter_if
//              req_valid/req_id/req_data in, req_ready out (combinational)
//              wake_valid/wake_id/broadcast out (registered)
//
//   A request with req_id == 0 has no destination: it is accepted in the
//   same cycle without consuming a bus or a grant slot.
// ---------------------------------------------------------------------------
module wake_bus_arbiter #(
    parameter int REQ_NUM      = 6,
    parameter int BUS_NUM      = 2,
    parameter int ID_W         = 6,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    wake_bus_arbiter_if.slave bus
);

    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]        starve_cnt [REQ_NUM];

    logic [BUS_NUM-1:0]      wake_valid_q;
    logic [BUS_NUM*ID_W-1:0] wake_id_q;
    logic [BUS_NUM*32-1:0]   broadcast_q;

    // -----------------------------------------------------------------------
    // Request classification
    // -----------------------------------------------------------------------
    logic [REQ_NUM-1:0] cand;      // valid and needs a bus
    logic [REQ_NUM-1:0] zero_id;   // valid with no destination register
    logic [REQ_NUM-1:0] starved;   // candidate that has waited STARVE_LIMIT cycles

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // up front, so no path leaves it unassigned and no latch is inferred.
        cand    = '0;
        zero_id = '0;
        starved = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (bus.req_valid[i]) begin
                if (bus.req_id[i*ID_W +: ID_W] == '0) begin
                    zero_id[i] = 1'b1;
                end else begin
                    cand[i] = 1'b1;
                end
            end
            starved[i] = cand[i] && (starve_cnt[i] == CNT_MAX);
        end
    end

    // -----------------------------------------------------------------------
    // Grant selection
    //   slot counts grants handed out so far this cycle; grant number slot
    //   lands on bus number slot. Starved requesters are served in a first
    //   pass, the round-robin pass then walks REQ_NUM positions from rr_ptr
    //   and skips anything the first pass already considered.
    // -----------------------------------------------------------------------
    logic [REQ_NUM-1:0]      grant;
    logic [PTR_W-1:0]        rr_ptr_nxt;
    logic [BUS_NUM-1:0]      nxt_valid;
    logic [BUS_NUM*ID_W-1:0] nxt_id;
    logic [BUS_NUM*32-1:0]   nxt_data;

    always_comb begin
        int slot;
        int idx;

        grant      = '0;
        rr_ptr_nxt = rr_ptr;
        nxt_valid  = '0;
        nxt_id     = '0;
        nxt_data   = '0;
        slot       = 0;
        idx        = 0;

        // Phase 1: starved candidates, lowest index first. These do not
        // move the round-robin pointer.
        for (int i = 0; i < REQ_NUM; i++) begin
            if (starved[i] && (slot < BUS_NUM)) begin
                grant[i]                      = 1'b1;
                nxt_valid[slot]               = 1'b1;
                nxt_id[slot*ID_W +: ID_W]     = bus.req_id[i*ID_W +: ID_W];
                nxt_data[slot*32 +: 32]       = bus.req_data[i*32 +: 32];
                slot                          = slot + 1;
            end
        end

        // Phase 2: remaining candidates in round-robin order. The pointer
        // ends up one past the last requester granted in this phase.
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= REQ_NUM) begin
                idx = idx - REQ_NUM;
            end
            if (cand[idx] && !starved[idx] && (slot < BUS_NUM)) begin
                grant[idx]                    = 1'b1;
                nxt_valid[slot]               = 1'b1;
                nxt_id[slot*ID_W +: ID_W]     = bus.req_id[idx*ID_W +: ID_W];
                nxt_data[slot*32 +: 32]       = bus.req_data[idx*32 +: 32];
                rr_ptr_nxt                    = (idx == REQ_NUM - 1) ? '0 : PTR_W'(idx + 1);
                slot                          = slot + 1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Handshake: nothing is accepted while reset or flush is asserted, since
    // the requesters are being cleared by the same signal.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.req_ready = '0;
        if (!reset && !flush) begin
            bus.req_ready = grant | zero_id;
        end
    end

    // -----------------------------------------------------------------------
    // Registered state and bus drivers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset || flush) begin
            // NOTE: the bus data/id registers are cleared along with the
            // control state because idle buses must drive zero, not stale data.
            wake_valid_q <= '0;
            wake_id_q    <= '0;
            broadcast_q  <= '0;
            rr_ptr       <= '0;
            for (int i = 0; i < REQ_NUM; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            wake_valid_q <= nxt_valid;
            wake_id_q    <= nxt_id;
            broadcast_q  <= nxt_data;
            rr_ptr       <= rr_ptr_nxt;
            for (int i = 0; i < REQ_NUM; i++) begin
                if (cand[i] && !grant[i]) begin
                    starve_cnt[i] <= (starve_cnt[i] == CNT_MAX) ? CNT_MAX
                                                                : starve_cnt[i] + 1'b1;
                end else begin
                    starve_cnt[i] <= '0;
                end
            end
        end
    end

    assign bus.wake_valid = wake_valid_q;
    assign bus.wake_id    = wake_id_q;
    assign bus.broadcast  = broadcast_q;

endmodule
